pwm_audio_out: RTL and testbench
================================

Name: pwm_audio_out

Overview:
Parametrised output stage replacing the fixed truncate-then-PWM pair at the end of the audio chain (ADC → filter bank → output). It takes signed filter samples and scales them by shift, with optional rounding and saturation, into offset-binary duty. It drives a free-running PWM with a duty register that updates only at the period boundary. It adds a pop-free soft mute with ramp and amplifier shutdown sequencing.

Parameters:
DATA_W, 25, width of signed input sample
PWM_W, 11, PWM resolution; period = 2^PWM_W clocks
SHIFT, 13, arithmetic right shift applied to the sample before saturation (SHIFT ≥ 1)
RAMP_STEP, 4, maximum duty change per PWM period while ramping
AMP_WAKE, 8, PWM periods to wait after amp enable before ramping up

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sample_valid  in  1  single-cycle strobe, sample_in valid
sample_in  in  DATA_W  signed two's-complement filter output
round_en  in  1  1 = round half-up before shift, 0 = truncate
mute  in  1  level; 1 requests soft mute
clr_flags  in  1  clears clip_flag and overrun_flag
pwm_out  out  1  registered PWM output
amp_sd  out  1  amplifier enable (1 = amplifier on)
period_start  out  1  one-cycle pulse when the PWM counter wraps to 0
clip_flag  out  1  sticky; a sample saturated
overflow_flag  out  1  sticky overrun; a second sample arrived in the same PWM period

Behaviour:
- Reset: cnt=0, duty_pending=duty_active=2^(PWM_W-1) (midscale), pwm_out=0, amp_sd=1, period_start=0, flags=0, state=RUN, wake counter=0.
- Conversion, on the cycle sample_valid=1:
  - s = round_en ? (sample_in + 2^(SHIFT-1)) >>> SHIFT : sample_in >>> SHIFT. Addition is done at DATA_W+1 bits; no wrap.
  - s is saturated to [-2^(PWM_W-1), 2^(PWM_W-1)-1]. clip_flag is set if clamping occurred.
  - duty_pending = s + 2^(PWM_W-1), registered. Latency: 1 clk from strobe to duty_pending.
- No backpressure. Multiple strobes within one period: last wins, and overrun_flag is set on the 2nd and later strobes.
- Flags: clr_flags clears both flags. If clr_flags and a set event coincide, the set wins.
- Counter: cnt increments every clk, modulo 2^PWM_W. period_start=1 in the cycle cnt==0.
- Duty update: duty_active updates only in the cycle cnt==2^PWM_W-1 (takes effect from cnt=0). Update rule per state:
  - RUN: duty_active ← duty_pending.
  - RAMP_DOWN: duty_active moves toward midscale by min(RAMP_STEP, distance).
  - RAMP_UP: duty_active moves toward duty_pending by min(RAMP_STEP, distance).
  - MUTED / WAKE: duty_active held at midscale.
- pwm_out: registered (cnt < duty_active). duty 0 gives constant 0. duty 2^PWM_W is unreachable (max duty 2^PWM_W-1 → high for all but one clk).
- FSM, transitions evaluated only at the period boundary (cnt==max) unless noted:
  - RUN: mute=1 → RAMP_DOWN.
  - RAMP_DOWN: duty reaches midscale → MUTED, amp_sd←0 on the next clk. mute=0 → RAMP_UP.
  - MUTED: mute=0 → WAKE, amp_sd←1 immediately (any cycle), wake counter←0.
  - WAKE: wake counter increments per period. At AMP_WAKE → RAMP_UP. mute=1 → MUTED, amp_sd←0.
  - RAMP_UP: duty_active==duty_pending → RUN. mute=1 → RAMP_DOWN.
- A sample arriving mid-ramp only changes duty_pending; the ramp target then follows it.
- Reset mid-operation: all state returns to reset values in the next cycle. PWM restarts at cnt=0.

Test Plan:
Tests use DATA_W=8, PWM_W=4, SHIFT=2, RAMP_STEP=1, AMP_WAKE=2 (period = 16 clk).
1. Basic: round_en=0, sample 20 → duty 13. After the next wrap, pwm_out high for 13 of 16 clks. period_start every 16 clks.
2. Round vs truncate: sample 22 → duty 13 with round_en=0, duty 14 with round_en=1. sample -3 → duty 7 truncated, duty 7 rounded (-3+2=-1>>>2=-1). clip_flag stays 0.
3. Saturation: sample 127 → duty 15, clip_flag=1. sample -128 → duty 0, pwm_out constantly 0. clr_flags → flag 0. clr_flags coincident with a clip event → flag 1.
4. Overrun: two strobes (20, then 40) inside one period → duty 15 (40>>>2=10 clipped to 7) and overrun_flag=1. A single strobe per period → overrun_flag stays 0.
5. Mute: at duty 13, assert mute → duty 12, 11, 10, 9, 8 over 5 periods. state MUTED, amp_sd=0 one clk later. Release mute → amp_sd=1 immediately, 2 periods at duty 8, then ramp 9..13, then RUN.
6. Reset mid-ramp: assert rst during RAMP_DOWN → next clk duty midscale, pwm_out=0, amp_sd=1, state RUN, flags 0.

Source files
------------

// File: rtl/pwm_audio_out.sv
`default_nettype none
// ============================================================================
// Module : pwm_audio_out
// Signed sample -> shifted/saturated offset-binary duty, free-running PWM,
// pop-free soft mute ramp and amplifier shutdown/wake sequencing.
// Rev    : 1.0
// ============================================================================
module pwm_audio_out #(
  parameter int DATA_W    = 25,
  parameter int PWM_W     = 11,
  parameter int SHIFT     = 13,
  parameter int RAMP_STEP = 4,
  parameter int AMP_WAKE  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              round_en,
  input  logic              mute,
  input  logic              clr_flags,
  output logic              pwm_out,
  output logic              amp_sd,
  output logic              period_start,
  output logic              clip_flag,
  output logic              overflow_flag
);

  localparam int CW   = (DATA_W + 1 > PWM_W + 1) ? DATA_W + 1 : PWM_W + 1;
  localparam int WK_W = $clog2(AMP_WAKE + 2);

  localparam logic [PWM_W-1:0] C_MID  = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [PWM_W-1:0] C_MAX  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] C_STEP =
    (RAMP_STEP >= (1 << PWM_W)) ? {PWM_W{1'b1}} : PWM_W'(RAMP_STEP);
  localparam logic [WK_W-1:0]  C_WAKE_LAST = WK_W'(AMP_WAKE);

  localparam logic signed [CW-1:0] C_RND    = $signed({{(CW-1){1'b0}}, 1'b1} << (SHIFT - 1));
  localparam logic signed [CW-1:0] C_SAT_HI = $signed({{(CW-PWM_W+1){1'b0}}, {(PWM_W-1){1'b1}}});
  localparam logic signed [CW-1:0] C_SAT_LO = $signed({{(CW-PWM_W+1){1'b1}}, {(PWM_W-1){1'b0}}});

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_RAMP_DOWN = 3'd1,
    ST_MUTED     = 3'd2,
    ST_WAKE      = 3'd3,
    ST_RAMP_UP   = 3'd4
  } state_t;

  state_t               state;
  logic [PWM_W-1:0]     cnt;
  logic [PWM_W-1:0]     duty_pending;
  logic [PWM_W-1:0]     duty_active;
  logic [WK_W-1:0]      wake_cnt;
  logic                 seen;

  logic signed [CW-1:0] ext;
  logic signed [CW-1:0] biased;
  logic signed [CW-1:0] shifted;
  logic [PWM_W-1:0]     conv_duty;
  logic [PWM_W-1:0]     ramp_down_next;
  logic [PWM_W-1:0]     ramp_up_next;
  logic                 clip_evt;
  logic                 ovr_evt;
  logic                 wrap;

  function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] tgt);
    if (cur < tgt) begin
      return (tgt - cur > C_STEP) ? cur + C_STEP : tgt;
    end else begin
      return (cur - tgt > C_STEP) ? cur - C_STEP : tgt;
    end
  endfunction

  always_comb begin
    ext     = {{(CW-DATA_W){sample_in[DATA_W-1]}}, sample_in};
    biased  = round_en ? ext + C_RND : ext;
    shifted = biased >>> SHIFT;
    clip_evt = sample_valid && ((shifted > C_SAT_HI) || (shifted < C_SAT_LO));
    // Offset binary: adding midscale to an in-range value just flips its sign bit.
    if (shifted > C_SAT_HI) begin
      conv_duty = C_MAX;
    end else if (shifted < C_SAT_LO) begin
      conv_duty = '0;
    end else begin
      conv_duty = {~shifted[PWM_W-1], shifted[PWM_W-2:0]};
    end
    ovr_evt        = sample_valid && seen;
    wrap           = (cnt == C_MAX);
    ramp_down_next = step_toward(duty_active, C_MID);
    ramp_up_next   = step_toward(duty_active, duty_pending);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      duty_pending  <= C_MID;
      duty_active   <= C_MID;
      pwm_out       <= 1'b0;
      amp_sd        <= 1'b1;
      period_start  <= 1'b0;
      clip_flag     <= 1'b0;
      overflow_flag <= 1'b0;
      seen          <= 1'b0;
      wake_cnt      <= '0;
      state         <= ST_RUN;
    end else begin
      cnt           <= cnt + 1'b1;
      period_start  <= wrap;
      pwm_out       <= (cnt < duty_active);
      seen          <= wrap ? 1'b0 : (seen | sample_valid);
      clip_flag     <= clip_evt | (clip_flag & ~clr_flags);
      overflow_flag <= ovr_evt  | (overflow_flag & ~clr_flags);
      if (sample_valid) begin
        duty_pending <= conv_duty;
      end

      case (state)
        ST_RUN: begin
          if (wrap) begin
            duty_active <= duty_pending;
            if (mute) state <= ST_RAMP_DOWN;
          end
        end
        ST_RAMP_DOWN: begin
          if (wrap) begin
            duty_active <= ramp_down_next;
            if (!mute) begin
              state <= ST_RAMP_UP;
            end else if (ramp_down_next == C_MID) begin
              state <= ST_MUTED;
            end
          end
        end
        ST_MUTED: begin
          // Wake is not tied to the period boundary; the amp powers up at once.
          if (!mute) begin
            state    <= ST_WAKE;
            amp_sd   <= 1'b1;
            wake_cnt <= '0;
          end else begin
            amp_sd   <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (wrap) begin
            duty_active <= C_MID;
            if (mute) begin
              state  <= ST_MUTED;
              amp_sd <= 1'b0;
            end else if (wake_cnt + 1'b1 >= C_WAKE_LAST) begin
              state <= ST_RAMP_UP;
            end else begin
              wake_cnt <= wake_cnt + 1'b1;
            end
          end
        end
        ST_RAMP_UP: begin
          if (wrap) begin
            duty_active <= ramp_up_next;
            if (mute) begin
              state <= ST_RAMP_DOWN;
            end else if (ramp_up_next == duty_pending) begin
              state <= ST_RUN;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_audio_out.sv
`default_nettype none
// ============================================================================
// Module : tb_pwm_audio_out
// Scoreboard bench: period-level reference model vs measured PWM high time.
// Rev    : 1.0
// ============================================================================
module tb_pwm_audio_out;

  localparam int DATA_W    = 8;
  localparam int PWM_W     = 4;
  localparam int SHIFT     = 2;
  localparam int RAMP_STEP = 1;
  localparam int AMP_WAKE  = 2;
  localparam int PERIOD    = 1 << PWM_W;
  localparam int MID       = PERIOD / 2;
  localparam int HALF_RNG  = PERIOD / 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample_in;
  logic                     round_en;
  logic                     mute;
  logic                     clr_flags;
  logic                     pwm_out;
  logic                     amp_sd;
  logic                     period_start;
  logic                     clip_flag;
  logic                     overflow_flag;

  pwm_audio_out #(
    .DATA_W(DATA_W), .PWM_W(PWM_W), .SHIFT(SHIFT),
    .RAMP_STEP(RAMP_STEP), .AMP_WAKE(AMP_WAKE)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .round_en(round_en), .mute(mute), .clr_flags(clr_flags),
    .pwm_out(pwm_out), .amp_sd(amp_sd), .period_start(period_start),
    .clip_flag(clip_flag), .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    bit clip;
    bit ovr;
    bit amp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int toward(input int d, input int t);
    if (d < t) return d + (((t - d) < RAMP_STEP) ? (t - d) : RAMP_STEP);
    return d - (((d - t) < RAMP_STEP) ? (d - t) : RAMP_STEP);
  endfunction

  // Reference model: level of mute mode, pending/active duty as plain integers.
  int    m_cnt, m_pend, m_act, m_wake, n_act, n_wake, mv, ms;
  bit    m_clip, m_ovr, m_amp, m_seen, n_amp, clip_ev, ovr_ev;
  string m_mode, n_mode;
  exp_t  m_e;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_pend = MID; m_act = MID; m_wake = 0;
      m_clip = 0; m_ovr = 0; m_amp = 1; m_seen = 0; m_mode = "run";
      exp_q.delete();
    end else begin
      clip_ev = 0; ovr_ev = 0; ms = 0;
      if (sample_valid) begin
        mv = int'(sample_in) + (round_en ? (1 << (SHIFT - 1)) : 0);
        ms = floor_div(mv, 1 << SHIFT);
        if (ms > HALF_RNG - 1) begin ms = HALF_RNG - 1; clip_ev = 1; end
        else if (ms < -HALF_RNG) begin ms = -HALF_RNG; clip_ev = 1; end
        ovr_ev = m_seen;
      end
      n_act = m_act; n_mode = m_mode; n_amp = m_amp; n_wake = m_wake;
      if (m_cnt == PERIOD - 1) begin
        if (m_mode == "run") begin
          n_act = m_pend;
          if (mute) n_mode = "down";
        end else if (m_mode == "down") begin
          n_act = toward(m_act, MID);
          if (!mute) n_mode = "up";
          else if (n_act == MID) n_mode = "muted";
        end else if (m_mode == "wake") begin
          if (mute) begin n_mode = "muted"; n_amp = 0; end
          else if (m_wake + 1 >= AMP_WAKE) n_mode = "up";
          else n_wake = m_wake + 1;
        end else if (m_mode == "up") begin
          n_act = toward(m_act, m_pend);
          if (mute) n_mode = "down";
          else if (n_act == m_pend) n_mode = "run";
        end
      end
      if (m_mode == "muted") begin
        if (!mute) begin n_mode = "wake"; n_amp = 1; n_wake = 0; end
        else n_amp = 0;
      end
      m_clip = clip_ev | (m_clip & !clr_flags);
      m_ovr  = ovr_ev  | (m_ovr  & !clr_flags);
      if (m_cnt == PERIOD - 1) begin
        m_e.duty = m_act; m_e.clip = m_clip; m_e.ovr = m_ovr; m_e.amp = n_amp;
        exp_q.push_back(m_e);
      end
      m_seen = (m_cnt == PERIOD - 1) ? 1'b0 : (m_seen | sample_valid);
      if (sample_valid) m_pend = ms + MID;
      m_act = n_act; m_mode = n_mode; m_amp = n_amp; m_wake = n_wake;
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  // Monitor: pwm_out lags cnt by one clk, so a period's window closes on period_start.
  int   hi = 0;
  exp_t got;
  always @(negedge clk) begin
    if (rst) begin
      hi = 0;
    end else begin
      hi += int'(pwm_out);
      if (period_start) begin
        if (exp_q.size() == 0) begin
          check("period_no_expect", 1, 0);
        end else begin
          got = exp_q.pop_front();
          pops++;
          check("duty_high_clks", hi, got.duty);
          check("clip_flag", int'(clip_flag), int'(got.clip));
          check("overflow_flag", int'(overflow_flag), int'(got.ovr));
          check("amp_sd", int'(amp_sd), int'(got.amp));
        end
        hi = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clr_flags    = 1'b0;
  endtask

  task automatic strobe(input int v, input bit r);
    sample_valid = 1'b1;
    sample_in    = DATA_W'(v);
    round_en     = r;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic to_phase(input int ph);
    while (m_cnt != ph) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm_out"}, int'(pwm_out), 0);
    check({tag, "_amp_sd"}, int'(amp_sd), 1);
    check({tag, "_period_start"}, int'(period_start), 0);
    check({tag, "_clip"}, int'(clip_flag), 0);
    check({tag, "_ovr"}, int'(overflow_flag), 0);
  endtask

  int r;

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0; round_en = 1'b0;
    mute = 1'b0; clr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    idle(2 * PERIOD);

    // Conversion: truncate/round, negative values, saturation both ends.
    to_phase(3); strobe(20, 0);  idle(2 * PERIOD);
    to_phase(3); strobe(22, 0);  idle(2 * PERIOD);
    to_phase(3); strobe(22, 1);  idle(2 * PERIOD);
    to_phase(3); strobe(-3, 0);  idle(2 * PERIOD);
    to_phase(3); strobe(-3, 1);  idle(2 * PERIOD);
    to_phase(3); strobe(127, 0); idle(2 * PERIOD);
    to_phase(3); strobe(-128, 0); idle(2 * PERIOD);
    clr_flags = 1'b1; tick(); idle(PERIOD);
    clr_flags = 1'b1; strobe(127, 1); idle(2 * PERIOD);
    clr_flags = 1'b1; tick();

    // Overrun: two strobes in one period, then one per period.
    to_phase(1); strobe(20, 0); idle(3); strobe(40, 0); idle(2 * PERIOD);
    clr_flags = 1'b1; tick();
    for (int p = 0; p < 3; p++) begin
      to_phase(5); strobe(12 + 4 * p, 0);
    end
    to_phase(15); strobe(16, 0); strobe(-16, 0); idle(2 * PERIOD);

    // Soft mute from duty 13, then wake.
    strobe(20, 0); idle(2 * PERIOD);
    mute = 1'b1; idle(9 * PERIOD);
    check("amp_off_muted", int'(amp_sd), 0);
    to_phase(7); mute = 1'b0; tick();
    check("amp_on_immediate", int'(amp_sd), 1);
    idle(10 * PERIOD);

    // Randomized samples, flag clears and mute toggles.
    for (int c = 0; c < 70 * PERIOD; c++) begin
      r = int'($urandom_range(0, 999));
      if (r < 60) begin
        sample_valid = 1'b1;
        round_en     = 1'(($urandom & 1));
        if (r < 30) sample_in = DATA_W'(int'($urandom_range(0, 63)) - 32);
        else        sample_in = DATA_W'($urandom_range(0, 255));
      end else if (r < 75) begin
        clr_flags = 1'b1;
      end else if (r < 82) begin
        mute = ~mute;
      end
      tick();
    end
    mute = 1'b0; idle(12 * PERIOD);

    // Reset while ramping down, with flags set.
    strobe(127, 0); idle(2 * PERIOD);
    to_phase(2); strobe(4, 0); strobe(127, 0); idle(PERIOD);
    mute = 1'b1; idle(3 * PERIOD + 5);
    rst = 1'b1; tick();
    rst = 1'b0; mute = 1'b0;
    check_reset_outputs("midramp_reset");
    idle(2 * PERIOD);
    strobe(20, 0); idle(3 * PERIOD);

    check("periods_checked", int'(pops > 100), 1);
    check("expect_queue_drained", int'(exp_q.size() <= 1), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
